// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: clears the MAC, streams len operand pairs into it, waits out its latency and returns the dot product on an ap_done/ap_continue handshake; defining MAC_SEQ_TIMEOUT_EN adds a stall timeout and the err port
module mac_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 21,
  parameter int LEN_W = 12,
  parameter int MAC_LAT = 2
`ifdef MAC_SEQ_TIMEOUT_EN
  ,
  parameter int TMO_CYC = 1024
`endif
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic              ap_continue,
  input  logic [LEN_W-1:0]  len,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              ap_done,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  output logic              mac_ce,
  output logic              mac_clr,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic [ACC_W-1:0]  rst,
  output logic              rst_ap_vld
`ifdef MAC_SEQ_TIMEOUT_EN
  ,
  output logic              err
`endif
);
  localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_STREAM = 3'd2, S_DRAIN = 3'd3, S_DONE = 3'd4;
  // drain counts 0..MAC_LAT so the capture cycle sees the last product already summed
  localparam int DW = MAC_LAT > 0 ? $clog2(MAC_LAT + 1) : 1;
`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TW = TMO_CYC > 1 ? $clog2(TMO_CYC) : 1;
  logic [TW-1:0] scnt;
`endif
  logic [2:0] state;
  logic [LEN_W-1:0] len_q, cnt;
  logic [DW-1:0] dcnt;
  logic fire;
  assign fire = state == S_STREAM && a_valid && b_valid;
  assign a_ready = state == S_STREAM && b_valid;
  assign b_ready = state == S_STREAM && a_valid;
  assign ap_idle = state == S_IDLE;
  assign ap_done = state == S_DONE;
  assign rst_ap_vld = ap_done;
  assign mac_clr = state == S_CLEAR;
  assign mac_ce = state == S_CLEAR || state == S_STREAM || state == S_DRAIN;
  // sequencer: operand registers feed zeros on every cycle without a joint handshake
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= S_IDLE;
      len_q <= '0;
      cnt <= '0;
      dcnt <= '0;
      mac_a <= '0;
      mac_b <= '0;
      rst <= '0;
      ap_ready <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
      scnt <= '0;
      err <= 1'b0;
`endif
    end else begin
      ap_ready <= 1'b0;
      mac_a <= fire ? a_data : '0;
      mac_b <= fire ? b_data : '0;
      case (state)
        S_IDLE: if (ap_start) begin
          len_q <= len;
          cnt <= '0;
`ifdef MAC_SEQ_TIMEOUT_EN
          scnt <= '0;
          err <= 1'b0;
`endif
          if (len == '0) begin
            rst <= '0;
            ap_ready <= 1'b1;
            state <= S_DONE;
          end else state <= S_CLEAR;
        end
        S_CLEAR: state <= S_STREAM;
        S_STREAM: if (fire) begin
          cnt <= cnt + 1'b1;
          dcnt <= '0;
`ifdef MAC_SEQ_TIMEOUT_EN
          scnt <= '0;
`endif
          if (cnt == len_q - 1'b1) state <= S_DRAIN;
        end
`ifdef MAC_SEQ_TIMEOUT_EN
        else if (scnt == TW'(TMO_CYC - 1)) begin
          err <= 1'b1;
          rst <= mac_acc;
          ap_ready <= 1'b1;
          state <= S_DONE;
        end else scnt <= scnt + 1'b1;
`endif
        S_DRAIN: if (dcnt == DW'(MAC_LAT)) begin
          rst <= mac_acc;
          ap_ready <= 1'b1;
          state <= S_DONE;
        end else dcnt <= dcnt + 1'b1;
        S_DONE: if (ap_continue) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: randomized bench with queue-based operand sources and a dot-product reference
`timescale 1ns/1ps
module tb_mac_seq_ctrl;
  localparam int DATA_W = 8, ACC_W = 21, LEN_W = 12, MAC_LAT = 2;
`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TMO_CYC = 16;
  localparam int TMO_LAT = TMO_CYC + 1;
`else
  localparam int TMO_LAT = 0;
`endif
  logic ap_clk = 0, ap_rst = 1, ap_start = 0, ap_continue = 0;
  logic [LEN_W-1:0] len = '0;
  logic ap_idle, ap_ready, ap_done, a_ready, b_ready, mac_ce, mac_clr, rst_ap_vld;
  logic a_valid = 0, b_valid = 0;
  logic [DATA_W-1:0] a_data, b_data, mac_a, mac_b;
  logic [ACC_W-1:0] mac_acc, rst;
`ifdef MAC_SEQ_TIMEOUT_EN
  logic err;
`endif
  logic [DATA_W-1:0] qa [64];
  logic [DATA_W-1:0] qb [64];
  int ia = 0, ib = 0, avail = 0, vmode = 0, cyc = 0, n_chk = 0, n_fail = 0;
  int viol = 0, last_acc = 0, ce_cnt = 0, clr_cnt = 0;
  bit tog = 0, ha = 0, hb = 0;
  logic [ACC_W-1:0] acc_m = '0, prod_m = '0;

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // two-stage MAC: product register then accumulator, frozen when mac_ce is low
  always @(posedge ap_clk) if (mac_ce) begin
    if (mac_clr) begin
      prod_m <= '0;
      acc_m <= '0;
    end else begin
      prod_m <= ACC_W'(int'(mac_a) * int'(mac_b));
      acc_m <= acc_m + prod_m;
    end
  end
  assign mac_acc = acc_m;
  assign a_data = ia < 64 ? qa[ia] : '0;
  assign b_data = ib < 64 ? qb[ib] : '0;

  mac_seq_ctrl #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)
`ifdef MAC_SEQ_TIMEOUT_EN
    , .TMO_CYC(TMO_CYC)
`endif
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_continue(ap_continue), .len(len),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .mac_ce(mac_ce), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
    .rst(rst), .rst_ap_vld(rst_ap_vld)
`ifdef MAC_SEQ_TIMEOUT_EN
    , .err(err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    tog = ~tog;
    a_valid = ia < avail && (vmode == 0 || (vmode == 1 ? $urandom_range(1, 0) == 1 : tog));
    b_valid = ib < avail && (vmode != 1 || $urandom_range(1, 0) == 1);
  endtask

  // advance one clock: pop sources on the handshakes seen last cycle, redrive, then sample at negedge
  task automatic tick();
    @(posedge ap_clk);
    #1;
    if (ha) ia++;
    if (hb) ib++;
    drive();
    @(negedge ap_clk);
    ha = a_valid && a_ready;
    hb = b_valid && b_ready;
    if (ha != hb || ((ap_idle || ap_done) && (a_ready || b_ready))) viol++;
    if (ha) last_acc = cyc;
    if (mac_ce) ce_cnt++;
    if (mac_clr) clr_cnt++;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin
      qa[i] = DATA_W'($urandom);
      qb[i] = DATA_W'($urandom);
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 64; i++) begin
      qa[i] = DATA_W'(v);
      qb[i] = DATA_W'(v);
    end
  endtask

  task automatic run(input int n, input int av, input int vm, input int hold, input bit exp_err);
    int s, dcy, tmo, used;
    logic [ACC_W-1:0] expv;
    used = n < av ? n : av;
    expv = '0;
    for (int i = 0; i < used; i++) expv += ACC_W'(int'(qa[i]) * int'(qb[i]));
    ia = 0;
    ib = 0;
    avail = av;
    vmode = vm;
    drive();
    ha = 0;
    hb = 0;
    viol = 0;
    ce_cnt = 0;
    clr_cnt = 0;
    last_acc = -1000;
    len = LEN_W'(n);
    ap_start = 1;
    ap_continue = hold == 0;
    s = cyc;
    tick();
    ap_start = 0;
    len = LEN_W'($urandom);
    tmo = 0;
    while (!ap_done && tmo < 3000) begin
      tick();
      tmo++;
    end
    dcy = cyc;
    check("done_seen", ap_done, 1);
    check("result", rst, expv);
    check("vld", rst_ap_vld, 1);
    check("ready_pulse", ap_ready, 1);
    check("popped_a", ia, used);
    check("popped_b", ib, used);
    check("handshake_rules", viol, 0);
    check("clr_count", clr_cnt, n == 0 ? 0 : 1);
`ifdef MAC_SEQ_TIMEOUT_EN
    check("err", err, exp_err);
`endif
    if (n == 0) begin
      check("len0_latency", dcy - s, 1);
      check("len0_ce", ce_cnt, 0);
    end else check("latency", dcy - last_acc, exp_err ? TMO_LAT : MAC_LAT + 2);
    if (hold == 0) begin
      tick();
      ap_continue = 0;
      check("done_1cyc", ap_done, 0);
      check("idle_after", ap_idle, 1);
      check("rst_hold_idle", rst, expv);
    end else begin
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_done", ap_done, 1);
        check("hold_ready_low", ap_ready, 0);
        check("hold_rst", rst, expv);
      end
      ap_continue = 1;
      ap_start = 1;
      len = 5;
      tick();
      ap_continue = 0;
      ap_start = 0;
      check("release_idle", ap_idle, 1);
      check("release_done", ap_done, 0);
      tick();
      check("start_in_done_ignored", ap_idle, 1);
      check("ce_idle", mac_ce, 0);
    end
  endtask

  initial begin
    int tmo;
    fill_rand();
    repeat (2) tick();
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_ready", ap_ready, 0);
    check("rst_ce", mac_ce, 0);
    check("rst_clr", mac_clr, 0);
    check("rst_result", rst, 0);
    check("rst_mac_a", mac_a, 0);
    check("rst_mac_b", mac_b, 0);
    ap_rst = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      qa[i] = DATA_W'(2 * i + 1);
      qb[i] = DATA_W'(2 * i + 2);
    end
    run(4, 4, 0, 3, 0);
    fill_rand();
    run(3, 3, 2, 0, 0);
    run(0, 0, 0, 1, 0);
    fill_const(255);
    run(2, 2, 0, 0, 0);
    fill_const(3);
    run(1, 1, 0, 2, 0);
    fill_const(255);
    run(40, 40, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      int n;
      fill_rand();
      n = $urandom_range(12, 1);
      run(n, n, $urandom_range(2, 0), $urandom_range(2, 0), 0);
    end
    fill_rand();
    ia = 0;
    ib = 0;
    avail = 8;
    vmode = 1;
    drive();
    len = 8;
    ap_start = 1;
    tick();
    ap_start = 0;
    tmo = 0;
    while (ia < 2 && tmo < 200) begin
      tick();
      tmo++;
    end
    vmode = 0;
    tick();
    check("pre_abort_busy", ap_idle, 0);
    ap_rst = 1;
    tick();
    check("abort_idle", ap_idle, 1);
    check("abort_a_ready", a_ready, 0);
    check("abort_b_ready", b_ready, 0);
    check("abort_rst", rst, 0);
    check("abort_ce", mac_ce, 0);
    check("abort_done", ap_done, 0);
    ap_rst = 0;
    ha = 0;
    hb = 0;
    tick();
    fill_rand();
    run(5, 5, 1, 1, 0);
`ifdef MAC_SEQ_TIMEOUT_EN
    fill_rand();
    run(5, 2, 0, 1, 1);
    fill_rand();
    run(3, 3, 0, 0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
